apb_slave_regfile: RTL and testbench

- APB3 completer: the responder end of the bridge's APB requester interface.
- Holds NUM_REGS 32-bit read/write registers and inserts WAIT_CYCLES wait states on every access.
- Serves as the bridge's APB-side target in integration and as a reusable peripheral register block.
- Pulses wr_strobe for one cycle per committed write so downstream logic can react without its own edge detection.

---
 rtl/apb_pkg.sv | 24 ++
 rtl/apb_slave_regfile_if.sv | 26 ++
 rtl/apb_wait_counter.sv | 51 +++++
 rtl/apb_slave_regfile.sv | 136 +++++++++++++
 tb/tb_apb_slave_regfile.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared APB completer definitions: FSM states, bus widths, wait-state limits
// and the request record latched on the setup edge.
package apb_pkg;

    localparam int unsigned APB_DATA_W   = 32;
    localparam int unsigned APB_LANE_W   = 2;
    localparam int unsigned APB_MAX_WAIT = 15;
    localparam int unsigned APB_CNT_W    = 4;
    localparam int unsigned APB_WIDX_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    // Transfer attributes captured at the setup edge
    typedef struct packed {
        logic                  write;
        logic                  valid;
        logic [APB_WIDX_W-1:0] idx;
    } apb_req_t;

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB3 signal bundle with requester (master) and completer (slave) views.
interface apb_slave_regfile_if #(
    parameter int unsigned ADDR_W = 12
);
    import apb_pkg::*;

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_W-1:0]     paddr;
    logic [APB_DATA_W-1:0] pwdata;
    logic [APB_DATA_W-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_wait_counter.sv
// Wait-state counter: loads the wait count at setup, counts down during the
// access phase and raises a registered ready when the count is exhausted.
module apb_wait_counter
    import apb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [APB_CNT_W-1:0] load_val_i,
    input  logic                 dec_i,
    input  logic                 clear_i,
    output logic                 ready_o
);

    logic [APB_CNT_W-1:0] cnt_q, cnt_d;
    logic                 ready_q, ready_d;

    // Next count / ready: clear on completion or abort, load on setup, else count down
    always_comb begin
        cnt_d   = cnt_q;
        ready_d = ready_q;
        if (clear_i) begin
            cnt_d   = '0;
            ready_d = 1'b0;
        end else if (load_i) begin
            cnt_d   = load_val_i;
            ready_d = (load_val_i == '0);
        end else if (dec_i && !ready_q) begin
            if (cnt_q <= APB_CNT_W'(1)) begin
                cnt_d   = '0;
                ready_d = 1'b1;
            end else begin
                cnt_d = cnt_q - APB_CNT_W'(1);
            end
        end
    end

    // Counter and ready registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign ready_o = ready_q;

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 completer with NUM_REGS 32-bit read/write registers and WAIT_CYCLES
// wait states per access. Define APB_SLV_PSLVERR_EN to report invalid
// addresses (out of range or misaligned) on pslverr; otherwise pslverr is 0.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    apb_slave_regfile_if.slave    apb,
    output logic                  wr_strobe,
    output logic [APB_WIDX_W-1:0] wr_idx
);

    localparam int unsigned IDX_W  = ADDR_W - APB_LANE_W;
    localparam int unsigned RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    apb_state_e            state_q, state_d;
    apb_req_t              req_q;
    logic [APB_DATA_W-1:0] regs_q [NUM_REGS];
    logic [APB_DATA_W-1:0] prdata_q;
    logic                  wr_strobe_q;
    logic [APB_WIDX_W-1:0] wr_idx_q;

    logic [IDX_W-1:0]      addr_idx;
    logic                  addr_ok;
    logic                  setup_go, done_go, abort_go;
    logic                  busy;
    logic                  pready_w;
    logic                  commit;

    assign addr_idx = apb.paddr[ADDR_W-1:APB_LANE_W];
    assign addr_ok  = (32'(addr_idx) < 32'(NUM_REGS)) &&
                      (apb.paddr[APB_LANE_W-1:0] == '0);
    assign busy     = (state_q != ST_IDLE);
    assign commit   = done_go && req_q.write && req_q.valid;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state and transfer events; completion may occur in SETUP when there are no wait states
    always_comb begin
        state_d  = state_q;
        setup_go = 1'b0;
        done_go  = 1'b0;
        abort_go = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (apb.psel && !apb.penable) begin
                    state_d  = ST_SETUP;
                    setup_go = 1'b1;
                end
            end
            ST_SETUP, ST_ACCESS: begin
                if (!apb.psel) begin
                    state_d  = ST_IDLE;
                    abort_go = 1'b1;
                end else if (apb.penable && pready_w) begin
                    state_d = ST_IDLE;
                    done_go = 1'b1;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    apb_wait_counter u_wait (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (setup_go),
        .load_val_i (APB_CNT_W'(WAIT_CYCLES)),
        .dec_i      (busy),
        .clear_i    (done_go | abort_go),
        .ready_o    (pready_w)
    );

    // Latch request and read data at setup; raise write strobe on committed writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q       <= '0;
            prdata_q    <= '0;
            wr_strobe_q <= 1'b0;
            wr_idx_q    <= '0;
        end else begin
            wr_strobe_q <= 1'b0;
            if (setup_go) begin
                req_q.write <= apb.pwrite;
                req_q.valid <= addr_ok;
                req_q.idx   <= APB_WIDX_W'(addr_idx);
                prdata_q    <= (!apb.pwrite && addr_ok) ? regs_q[RIDX_W'(addr_idx)] : '0;
            end
            if (commit) begin
                wr_strobe_q <= 1'b1;
                wr_idx_q    <= req_q.idx;
            end
        end
    end

    // Register array, updated only on a committed valid write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (commit) begin
            regs_q[RIDX_W'(req_q.idx)] <= apb.pwdata;
        end
    end

`ifdef APB_SLV_PSLVERR_EN
    logic pslverr_q;

    // Error flag latched at setup, held through the access phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  pslverr_q <= 1'b0;
        else if (setup_go)           pslverr_q <= !addr_ok;
        else if (done_go | abort_go) pslverr_q <= 1'b0;
    end

    assign apb.pslverr = pslverr_q;
`else
    assign apb.pslverr = 1'b0;
`endif

    assign apb.prdata = prdata_q;
    assign apb.pready = pready_w;
    assign wr_strobe  = wr_strobe_q;
    assign wr_idx     = wr_idx_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: one instance with two wait states,
// one with none. Honors APB_SLV_PSLVERR_EN for the expected error response.
module tb_apb_slave_regfile;

`ifdef APB_SLV_PSLVERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    localparam bit U2 = 1'b0;  // WAIT_CYCLES = 2 instance
    localparam bit U0 = 1'b1;  // WAIT_CYCLES = 0 instance

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    logic       stb2, stb0;
    logic [7:0] widx2, widx0;

    apb_slave_regfile_if #(.ADDR_W(12)) bus2 ();
    apb_slave_regfile_if #(.ADDR_W(12)) bus0 ();

    apb_slave_regfile #(.NUM_REGS(16), .ADDR_W(12), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .apb(bus2), .wr_strobe(stb2), .wr_idx(widx2)
    );

    apb_slave_regfile #(.NUM_REGS(16), .ADDR_W(12), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .apb(bus0), .wr_strobe(stb0), .wr_idx(widx0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit u, input logic sel, input logic en, input logic wr,
                         input logic [11:0] addr, input logic [31:0] wd);
        if (u == U0) begin
            bus0.psel = sel; bus0.penable = en; bus0.pwrite = wr;
            bus0.paddr = addr; bus0.pwdata = wd;
        end else begin
            bus2.psel = sel; bus2.penable = en; bus2.pwrite = wr;
            bus2.paddr = addr; bus2.pwdata = wd;
        end
    endtask

    function automatic logic pready_of(input bit u);
        return (u == U0) ? bus0.pready : bus2.pready;
    endfunction

    function automatic logic [31:0] prdata_of(input bit u);
        return (u == U0) ? bus0.prdata : bus2.prdata;
    endfunction

    function automatic logic pslverr_of(input bit u);
        return (u == U0) ? bus0.pslverr : bus2.pslverr;
    endfunction

    function automatic logic strobe_of(input bit u);
        return (u == U0) ? stb0 : stb2;
    endfunction

    function automatic logic [7:0] widx_of(input bit u);
        return (u == U0) ? widx0 : widx2;
    endfunction

    // Full transfer starting at a negedge; returns at the negedge after completion
    task automatic xfer(input bit u, input logic wr, input logic [11:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic err,
                        output int acc, output logic stb, output logic [7:0] widx,
                        output int start);
        start = cyc;
        drive(u, 1'b1, 1'b0, wr, addr, wd);
        @(negedge clk);
        drive(u, 1'b1, 1'b1, wr, addr, wd);
        acc = 1;
        while (!pready_of(u) && acc < 40) begin
            @(negedge clk);
            acc++;
        end
        rd  = prdata_of(u);
        err = pslverr_of(u);
        @(negedge clk);
        stb  = strobe_of(u);
        widx = widx_of(u);
    endtask

    task automatic idle(input bit u);
        drive(u, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    endtask

    logic [31:0] rd;
    logic        err, stb;
    logic [7:0]  widx;
    int          acc, s0, s1, s2, s3;

    initial begin
        idle(U2);
        idle(U0);
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_pready2",  32'(bus2.pready), 32'd0);
        check("rst_prdata2",  bus2.prdata, 32'h0);
        check("rst_pslverr2", 32'(bus2.pslverr), 32'd0);
        check("rst_strobe2",  32'(stb2), 32'd0);
        check("rst_widx2",    32'(widx2), 32'd0);
        check("rst_pready0",  32'(bus0.pready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: write then read with two wait states
        xfer(U2, 1'b1, 12'h008, 32'hDEADBEEF, rd, err, acc, stb, widx, s0);
        check("t1_wr_acc",    32'(acc), 32'd3);
        check("t1_wr_strobe", 32'(stb), 32'd1);
        check("t1_wr_idx",    32'(widx), 32'd2);
        check("t1_wr_err",    32'(err), 32'd0);
        idle(U2);
        @(negedge clk);
        check("t1_strobe_once", 32'(stb2), 32'd0);
        xfer(U2, 1'b0, 12'h008, 32'h0, rd, err, acc, stb, widx, s0);
        check("t1_rd_data",   rd, 32'hDEADBEEF);
        check("t1_rd_acc",    32'(acc), 32'd3);
        check("t1_rd_strobe", 32'(stb), 32'd0);
        idle(U2);

        // penable without psel in IDLE is ignored
        drive(U2, 1'b0, 1'b1, 1'b0, 12'h008, 32'h0);
        @(negedge clk);
        check("perr_pready_a", 32'(bus2.pready), 32'd0);
        @(negedge clk);
        check("perr_pready_b", 32'(bus2.pready), 32'd0);
        idle(U2);
        @(negedge clk);

        // 2: zero wait states, back-to-back
        xfer(U0, 1'b1, 12'h000, 32'h11111111, rd, err, acc, stb, widx, s0);
        check("t2_w0_acc",    32'(acc), 32'd1);
        check("t2_w0_strobe", 32'(stb), 32'd1);
        check("t2_w0_idx",    32'(widx), 32'd0);
        xfer(U0, 1'b1, 12'h004, 32'h22222222, rd, err, acc, stb, widx, s1);
        check("t2_w1_acc",    32'(acc), 32'd1);
        check("t2_w1_strobe", 32'(stb), 32'd1);
        check("t2_w1_idx",    32'(widx), 32'd1);
        xfer(U0, 1'b0, 12'h000, 32'h0, rd, err, acc, stb, widx, s2);
        check("t2_r0_data",   rd, 32'h11111111);
        check("t2_r0_acc",    32'(acc), 32'd1);
        xfer(U0, 1'b0, 12'h004, 32'h0, rd, err, acc, stb, widx, s3);
        check("t2_r1_data",   rd, 32'h22222222);
        check("t2_r1_acc",    32'(acc), 32'd1);
        check("t2_gap01",     32'(s1 - s0), 32'd2);
        check("t2_gap12",     32'(s2 - s1), 32'd2);
        check("t2_gap23",     32'(s3 - s2), 32'd2);
        idle(U0);

        // 3: out-of-range read
        xfer(U2, 1'b0, 12'h040, 32'h0, rd, err, acc, stb, widx, s0);
        check("t3_rd_data", rd, 32'h0);
        check("t3_rd_err",  32'(err), 32'(ERR_EXP));
        check("t3_rd_acc",  32'(acc), 32'd3);
        idle(U2);
        @(negedge clk);

        // 4: misaligned write is dropped
        xfer(U2, 1'b1, 12'h006, 32'h12345678, rd, err, acc, stb, widx, s0);
        check("t4_strobe", 32'(stb), 32'd0);
        check("t4_err",    32'(err), 32'(ERR_EXP));
        check("t4_widx",   32'(widx), 32'd2);
        xfer(U2, 1'b0, 12'h004, 32'h0, rd, err, acc, stb, widx, s0);
        check("t4_reg1",   rd, 32'h0);
        xfer(U2, 1'b0, 12'h008, 32'h0, rd, err, acc, stb, widx, s0);
        check("t4_reg2",   rd, 32'hDEADBEEF);
        check("t4_rd_err", 32'(err), 32'd0);
        idle(U2);
        @(negedge clk);

        // 5: abort in the second access cycle of a write
        drive(U2, 1'b1, 1'b0, 1'b1, 12'h00C, 32'hAAAA5555);
        @(negedge clk);
        drive(U2, 1'b1, 1'b1, 1'b1, 12'h00C, 32'hAAAA5555);
        @(negedge clk);
        check("t5_pready_acc2", 32'(bus2.pready), 32'd0);
        idle(U2);
        @(negedge clk);
        check("t5_pready_after", 32'(bus2.pready), 32'd0);
        check("t5_strobe_a",     32'(stb2), 32'd0);
        @(negedge clk);
        check("t5_strobe_b",     32'(stb2), 32'd0);
        check("t5_pready_b",     32'(bus2.pready), 32'd0);
        xfer(U2, 1'b0, 12'h00C, 32'h0, rd, err, acc, stb, widx, s0);
        check("t5_reg3", rd, 32'h0);
        check("t5_acc",  32'(acc), 32'd3);
        idle(U2);
        @(negedge clk);

        // 6: reset in the middle of a write's wait states
        drive(U2, 1'b1, 1'b0, 1'b1, 12'h010, 32'h5A5A5A5A);
        @(negedge clk);
        drive(U2, 1'b1, 1'b1, 1'b1, 12'h010, 32'h5A5A5A5A);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_pready", 32'(bus2.pready), 32'd0);
        check("t6_rst_strobe", 32'(stb2), 32'd0);
        check("t6_rst_prdata", bus2.prdata, 32'h0);
        idle(U2);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_strobe_idle", 32'(stb2), 32'd0);
        xfer(U2, 1'b0, 12'h008, 32'h0, rd, err, acc, stb, widx, s0);
        check("t6_reg2", rd, 32'h0);
        xfer(U2, 1'b0, 12'h010, 32'h0, rd, err, acc, stb, widx, s0);
        check("t6_reg4", rd, 32'h0);
        xfer(U0, 1'b0, 12'h004, 32'h0, rd, err, acc, stb, widx, s0);
        check("t6_u0_reg1", rd, 32'h0);
        idle(U0);
        xfer(U2, 1'b1, 12'h010, 32'hCAFEF00D, rd, err, acc, stb, widx, s0);
        check("t6_wr_acc",    32'(acc), 32'd3);
        check("t6_wr_strobe", 32'(stb), 32'd1);
        check("t6_wr_idx",    32'(widx), 32'd4);
        xfer(U2, 1'b0, 12'h010, 32'h0, rd, err, acc, stb, widx, s0);
        check("t6_rd_data",   rd, 32'hCAFEF00D);
        idle(U2);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
